// File: rtl/adc_evt_packer_pkg.sv
// Shared types, widths and word formatters for the ADC event packer.
// Everything that defines the on-wire word layout lives here.
package adc_evt_packer_pkg;

   localparam int WORD_W    = 32;
   localparam int SAMP_W    = 12;
   localparam int NSAMP_W   = 10;
   localparam int EVT_W     = 16;
   localparam int TS_W      = 32;
   localparam int BUF_DEPTH = 16;
   localparam int BUF_CNT_W = $clog2(BUF_DEPTH + 1);

   localparam logic [7:0] HDR_MARKER = 8'hA5;
   localparam logic [7:0] TRL_MARKER = 8'h5A;

   // Header, timestamp and one data word must fit before an event may start.
   localparam logic [BUF_CNT_W-1:0] MIN_FREE_AT_TRIG = BUF_CNT_W'(3);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_TS,
      ST_DATA,
      ST_TRL
   } state_e;

   // Sample count is forced even (samples are packed in pairs) and at least 2.
   function automatic logic [NSAMP_W-1:0] eff_nsamp(input logic [NSAMP_W-1:0] cfg);
      logic [NSAMP_W-1:0] even;
      even = {cfg[NSAMP_W-1:1], 1'b0};
      return (even < NSAMP_W'(2)) ? NSAMP_W'(2) : even;
   endfunction

   function automatic logic [WORD_W-1:0] hdr_word(input logic ch, input logic [EVT_W-1:0] evt);
      return {HDR_MARKER, ch, 7'b0, evt};
   endfunction

   function automatic logic [WORD_W-1:0] trl_word(input logic ch, input logic ovf,
                                                  input logic [NSAMP_W-1:0] n);
      return {TRL_MARKER, ch, ovf, 12'b0, n};
   endfunction

   function automatic logic [WORD_W-1:0] pair_word(input logic [SAMP_W-1:0] first,
                                                   input logic [SAMP_W-1:0] second);
      return {4'b0, first, 4'b0, second};
   endfunction

endpackage

// File: rtl/sc_fifo.sv
// Single-clock FIFO with free-entry count. Read data is the head word
// (zero when empty), so it stays stable until the entry is popped.
module sc_fifo
   import adc_evt_packer_pkg::*;
#(
   parameter int WIDTH = WORD_W,
   parameter int DEPTH = BUF_DEPTH
) (
   input  logic                         clk,
   input  logic                         srst,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             pop_data,
   output logic                         empty,
   output logic                         full,
   output logic [$clog2(DEPTH+1)-1:0]   free
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok, pop_ok;

   assign empty    = (count_q == '0);
   assign full     = (count_q == CW'(DEPTH));
   assign free     = CW'(DEPTH) - count_q;
   assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      // Fullness is judged before any same-cycle pop, so push-on-full is dropped.
      push_ok  = push && !full;
      pop_ok   = pop && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/adc_evt_packer.sv
// Packs triggered two-channel ADC captures into framed 32-bit word streams
// (header, timestamp, sample pairs, trailer), one buffered stream per channel.
module adc_evt_packer
   import adc_evt_packer_pkg::*;
(
   input  logic                clk_clk,
   input  logic                reset_reset,
   input  logic                ext_rst,
   input  logic                write_en,
   input  logic                exttrg,
   input  logic [NSAMP_W-1:0]  nsamp_cfg,
   input  logic                adc_valid,
   input  logic [SAMP_W-1:0]   adc0_data,
   input  logic [SAMP_W-1:0]   adc1_data,
   output logic [WORD_W-1:0]   fifo0_writedata,
   output logic                fifo0_write,
   input  logic                fifo0_waitrequest,
   output logic [WORD_W-1:0]   fifo1_writedata,
   output logic                fifo1_write,
   input  logic                fifo1_waitrequest,
   output logic                busy,
   output logic [EVT_W-1:0]    evt_count
);

   state_e               state_q, state_d;
   logic [TS_W-1:0]      ts_q, ts_d;
   logic [TS_W-1:0]      ts_lat_q, ts_lat_d;
   logic [NSAMP_W-1:0]   nsamp_q, nsamp_d;
   logic [NSAMP_W-1:0]   samp_cnt_q, samp_cnt_d;
   logic [SAMP_W-1:0]    hold0_q, hold0_d;
   logic [SAMP_W-1:0]    hold1_q, hold1_d;
   logic                 ovf0_q, ovf0_d;
   logic                 ovf1_q, ovf1_d;
   logic [EVT_W-1:0]     evt_count_q, evt_count_d;

   logic                 soft_clr;
   logic                 trig_ok;
   logic                 body_push;
   logic                 push0, push1;
   logic [WORD_W-1:0]    wdata0, wdata1;
   logic                 f0_empty, f0_full, f1_empty, f1_full;
   logic [BUF_CNT_W-1:0] f0_free, f1_free;
   logic                 f0_pop, f1_pop;

   assign soft_clr  = reset_reset | ext_rst;
   assign busy      = (state_q != ST_IDLE);
   assign evt_count = evt_count_q;
   assign trig_ok   = exttrg && write_en &&
                      (f0_free >= MIN_FREE_AT_TRIG) && (f1_free >= MIN_FREE_AT_TRIG);
   assign ts_d      = ts_q + TS_W'(1);

   always_comb begin
      state_d     = state_q;
      ts_lat_d    = ts_lat_q;
      nsamp_d     = nsamp_q;
      samp_cnt_d  = samp_cnt_q;
      hold0_d     = hold0_q;
      hold1_d     = hold1_q;
      ovf0_d      = ovf0_q;
      ovf1_d      = ovf1_q;
      evt_count_d = evt_count_q;
      body_push   = 1'b0;
      push0       = 1'b0;
      push1       = 1'b0;
      wdata0      = '0;
      wdata1      = '0;

      case (state_q)
         ST_IDLE: begin
            if (trig_ok) begin
               ts_lat_d   = ts_q;
               nsamp_d    = eff_nsamp(nsamp_cfg);
               samp_cnt_d = '0;
               ovf0_d     = 1'b0;
               ovf1_d     = 1'b0;
               state_d    = ST_HDR;
            end
         end
         ST_HDR: begin
            body_push = 1'b1;
            wdata0    = hdr_word(1'b0, evt_count_q);
            wdata1    = hdr_word(1'b1, evt_count_q);
            state_d   = ST_TS;
         end
         ST_TS: begin
            body_push = 1'b1;
            wdata0    = ts_lat_q;
            wdata1    = ts_lat_q;
            state_d   = ST_DATA;
         end
         ST_DATA: begin
            if (adc_valid) begin
               // Even-indexed samples are parked; the odd one completes the pair.
               if (!samp_cnt_q[0]) begin
                  hold0_d = adc0_data;
                  hold1_d = adc1_data;
               end else begin
                  body_push = 1'b1;
                  wdata0    = pair_word(hold0_q, adc0_data);
                  wdata1    = pair_word(hold1_q, adc1_data);
               end
               samp_cnt_d = samp_cnt_q + NSAMP_W'(1);
               if (samp_cnt_d == nsamp_q) begin
                  state_d = ST_TRL;
               end
            end
         end
         ST_TRL: begin
            if (!f0_full && !f1_full) begin
               push0       = 1'b1;
               push1       = 1'b1;
               wdata0      = trl_word(1'b0, ovf0_q, nsamp_q);
               wdata1      = trl_word(1'b1, ovf1_q, nsamp_q);
               evt_count_d = evt_count_q + EVT_W'(1);
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (body_push) begin
         push0 = 1'b1;
         push1 = 1'b1;
         if (f0_full) ovf0_d = 1'b1;
         if (f1_full) ovf1_d = 1'b1;
      end
   end

   // The timestamp survives the soft reset; only the hard reset clears it.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         ts_q <= '0;
      end else begin
         ts_q <= ts_d;
      end
   end

   always_ff @(posedge clk_clk) begin
      if (soft_clr) begin
         state_q     <= ST_IDLE;
         ts_lat_q    <= '0;
         nsamp_q     <= '0;
         samp_cnt_q  <= '0;
         hold0_q     <= '0;
         hold1_q     <= '0;
         ovf0_q      <= 1'b0;
         ovf1_q      <= 1'b0;
         evt_count_q <= '0;
      end else begin
         state_q     <= state_d;
         ts_lat_q    <= ts_lat_d;
         nsamp_q     <= nsamp_d;
         samp_cnt_q  <= samp_cnt_d;
         hold0_q     <= hold0_d;
         hold1_q     <= hold1_d;
         ovf0_q      <= ovf0_d;
         ovf1_q      <= ovf1_d;
         evt_count_q <= evt_count_d;
      end
   end

   assign fifo0_write = !f0_empty;
   assign fifo1_write = !f1_empty;
   assign f0_pop      = fifo0_write && !fifo0_waitrequest;
   assign f1_pop      = fifo1_write && !fifo1_waitrequest;

   sc_fifo #(.WIDTH(WORD_W), .DEPTH(BUF_DEPTH)) u_buf0 (
      .clk       (clk_clk),
      .srst      (soft_clr),
      .push      (push0),
      .push_data (wdata0),
      .pop       (f0_pop),
      .pop_data  (fifo0_writedata),
      .empty     (f0_empty),
      .full      (f0_full),
      .free      (f0_free)
   );

   sc_fifo #(.WIDTH(WORD_W), .DEPTH(BUF_DEPTH)) u_buf1 (
      .clk       (clk_clk),
      .srst      (soft_clr),
      .push      (push1),
      .push_data (wdata1),
      .pop       (f1_pop),
      .pop_data  (fifo1_writedata),
      .empty     (f1_empty),
      .full      (f1_full),
      .free      (f1_free)
   );

endmodule
